cache_axi_bridge: RTL

Converts the cache's memory-side miss/writeback interface (rd_req/ret_* and wr_req/wr_*) into AXI master transactions, and sits directly downstream of the cache.
Has one independent read engine and one write engine with a single-entry line buffer, so a victim writeback and a refill read can be in flight together.
Uncached single-word/halfword/byte accesses use the same paths as single-beat transfers.

---
 rtl/cache_axi_pkg.sv | 37 +++
 rtl/cache_axi_bridge_if.sv | 59 +++++
 rtl/axi_wr_chan.sv | 129 ++++++++++++
 rtl/cache_axi_bridge.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared encodings and helpers
// for the cache-to-AXI bridge.
package cache_axi_pkg;

  localparam int DEF_LINE_BYTES = 16;
  localparam int BEATS = DEF_LINE_BYTES / 4;

  localparam logic [2:0] TY_BYTE = 3'b000;
  localparam logic [2:0] TY_HALF = 3'b001;
  localparam logic [2:0] TY_WORD = 3'b010;
  localparam logic [2:0] TY_LINE = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
  } axi_ls_t;

  function automatic axi_ls_t type_ls(
    input logic [2:0] ty,
    input int         beats
  );
    axi_ls_t r;
    r.len  = 8'd0;
    r.size = 3'd2;
    case (ty)
      TY_LINE: r.len  = 8'(beats - 1);
      TY_WORD: r.size = 3'd2;
      TY_HALF: r.size = 3'd1;
      TY_BYTE: r.size = 3'd0;
      default: r.size = 3'd2;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if: AXI4 master bus bundle
// between the bridge and the memory system.
interface cache_axi_bridge_if #(
  parameter int ADDR_W = 32
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arid;

  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awid;

  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;

  modport master (
    output arvalid, araddr, arlen, arsize,
    output arburst, arid, rready,
    output awvalid, awaddr, awlen, awsize,
    output awburst, awid,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  arready, rvalid, rdata, rlast,
    input  awready, wready, bvalid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize,
    input  arburst, arid, rready,
    input  awvalid, awaddr, awlen, awsize,
    input  awburst, awid,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output arready, rvalid, rdata, rlast,
    output awready, wready, bvalid
  );

endinterface

// File: rtl/axi_wr_chan.sv
// axi_wr_chan: single-entry write buffer with
// independent AW / W issue and B collection.
module axi_wr_chan
  import cache_axi_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [LINE_BYTES*8-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    busy,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0] line_addr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_W-1:0]       awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [3:0]              awid,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int OFF = $clog2(LINE_BYTES);
  localparam int NB  = LINE_BYTES / 4;
  localparam int LW  = $clog2(NB);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_SEND = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [1:0]              w_state;
  logic [ADDR_W-1:0]       addr;
  axi_ls_t                 ls;
  logic                    is_line;
  logic [3:0]              strb;
  logic [LINE_BYTES*8-1:0] line_q;
  logic [7:0]              cnt;
  logic                    aw_done;
  logic                    w_done;
  logic [LW-1:0]           idx;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    last_hs;

  assign wr_rdy    = (w_state == W_IDLE);
  assign busy      = !wr_rdy;
  assign line_addr = addr[ADDR_W-1:OFF];

  assign idx = is_line ? cnt[LW-1:0]
                       : addr[OFF-1:2];

  assign awvalid = (w_state == W_SEND) && !aw_done;
  assign awaddr  = addr;
  assign awlen   = ls.len;
  assign awsize  = ls.size;
  assign awburst = BURST_INCR;
  assign awid    = 4'd0;

  assign wvalid = (w_state == W_SEND) && !w_done;
  assign wdata  = line_q[idx*32 +: 32];
  assign wstrb  = is_line ? 4'hf : strb;
  assign wlast  = (cnt == ls.len);
  assign bready = (w_state == W_RESP);

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign last_hs = w_hs && wlast;

  // Write FSM: latch request, send AW and W
  // independently, then wait for the response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      addr    <= '0;
      ls      <= '0;
      is_line <= 1'b0;
      strb    <= '0;
      line_q  <= '0;
      cnt     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_req) begin
            addr    <= wr_addr;
            ls      <= type_ls(wr_type, NB);
            is_line <= (wr_type == TY_LINE);
            strb    <= wr_wstrb;
            line_q  <= wr_data;
            cnt     <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_state <= W_SEND;
          end
        end
        W_SEND: begin
          if (aw_hs)
            aw_done <= 1'b1;
          if (w_hs && !wlast)
            cnt <= cnt + 8'd1;
          if (last_hs)
            w_done <= 1'b1;
          if ((aw_done || aw_hs) &&
              (w_done || last_hs))
            w_state <= W_RESP;
        end
        W_RESP: begin
          if (bvalid)
            w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: cache miss/writeback port
// to AXI master, independent read and write engines.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rd_req,
  input  logic [2:0]              rd_type,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [LINE_BYTES*8-1:0] wr_data,
  output logic                    wr_rdy,
  cache_axi_bridge_if.master      axi
);

  localparam int OFF = $clog2(LINE_BYTES);
  localparam int NB  = LINE_BYTES / 4;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_W-1:0]     ar_addr;
  axi_ls_t               ar_ls;
  logic                  wb_busy;
  logic [ADDR_W-OFF-1:0] wb_line;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  hazard;
  logic                  r_done;

  assign wr_fire = wr_req && wr_rdy;

  // A read must not pass a pending or
  // same-cycle write to the same line.
  assign hazard =
    (wb_busy &&
     rd_addr[ADDR_W-1:OFF] == wb_line) ||
    (wr_fire &&
     rd_addr[ADDR_W-1:OFF] ==
     wr_addr[ADDR_W-1:OFF]);

  assign rd_rdy  = (r_state == R_IDLE) && !hazard;
  assign rd_fire = rd_req && rd_rdy;
  assign r_done  = axi.rvalid && axi.rlast;

  assign axi.arvalid = (r_state == R_AR);
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = ar_ls.len;
  assign axi.arsize  = ar_ls.size;
  assign axi.arburst = BURST_INCR;
  assign axi.arid    = 4'd0;
  assign axi.rready  = (r_state == R_DATA);

  assign ret_valid = axi.rready && axi.rvalid;
  assign ret_last  = ret_valid && axi.rlast;
  assign ret_data  = axi.rdata;

  // Read FSM: latch request, issue AR,
  // stream R beats until rlast.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      ar_addr <= '0;
      ar_ls   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_fire) begin
            ar_addr <= rd_addr;
            ar_ls   <= type_ls(rd_type, NB);
            r_state <= R_AR;
          end
        end
        R_AR: begin
          if (axi.arready)
            r_state <= R_DATA;
        end
        R_DATA: begin
          if (r_done)
            r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi_wr_chan #(
    .LINE_BYTES (LINE_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_wr (
    .clk       (clk),
    .resetn    (resetn),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .busy      (wb_busy),
    .line_addr (wb_line),
    .awvalid   (axi.awvalid),
    .awready   (axi.awready),
    .awaddr    (axi.awaddr),
    .awlen     (axi.awlen),
    .awsize    (axi.awsize),
    .awburst   (axi.awburst),
    .awid      (axi.awid),
    .wvalid    (axi.wvalid),
    .wready    (axi.wready),
    .wdata     (axi.wdata),
    .wstrb     (axi.wstrb),
    .wlast     (axi.wlast),
    .bvalid    (axi.bvalid),
    .bready    (axi.bready)
  );

endmodule
